bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
- Parametrised N-digit BCD up/down counter; next-generation replacement for the fixed 2-digit 00–99 LED counter.
- Adds digit-count parameter, direction control, count enable, synchronous parallel load, terminal-count output and a sticky wrap flag.
- Drives LED/7-seg display paths directly.
- Cascadable through tc into another instance's en.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..8; count range 0 .. (10^DIGITS)-1.

Ports:
- ck  input  1  clock; all state updates on rising edge.
- rs  input  1  reset; asynchronous, active-high.
- en  input  1  count enable; one step per ck edge while high.
- up  input  1  direction; 1 = increment, 0 = decrement; sampled only when en=1.
- ld  input  1  synchronous load strobe.
- ld_val  input  4*DIGITS  load value, digit 0 in bits [3:0].
- q  output  4*DIGITS  count value, packed BCD, digit 0 = least significant, bits [3:0].
- tc  output  1  terminal count, combinational.
- wrap  output  1  sticky wrap flag, registered.

Behaviour:
- Reset: rs=1 forces q=0 and wrap=0 immediately, with no ck edge required. While rs is held, rs overrides all other inputs.
- Priority at each ck edge: rs > ld > en. If en=0 and ld=0, q and wrap hold.
- Load (ld=1):
  - q <= ld_val on the next edge; en and up are ignored that cycle.
  - Any ld_val digit >9 (0xA–0xF) loads as 0. Other digits load unchanged.
  - Load clears wrap to 0.
- Increment (en=1, up=1), per digit:
  - Digit 0 always steps.
  - Digit k steps only when digits 0..k-1 are all 9.
  - A stepping digit at 9 becomes 0; otherwise it increments by 1.
  - Example: 0x099 -> 0x100.
- Decrement (en=1, up=0), per digit:
  - Digit k steps only when digits 0..k-1 are all 0.
  - A stepping digit at 0 becomes 9; otherwise it decrements by 1.
  - Example: 0x100 -> 0x099.
- Latency: one ck edge from en/ld to the new q. No pipeline.
- Boundary, up: count at all 9s (99 for DIGITS=2) with en=1, up=1 wraps to all 0s on the next edge.
- Boundary, down: count at all 0s with en=1, up=0 wraps to all 9s on the next edge.
- wrap flag:
  - Set on the edge where either wrap occurs.
  - Stays set until rs or ld.
  - Not cleared by counting.
- tc = en & (up ? q==all 9s : q==all 0s), with ld=0.
  - tc is 0 whenever ld=1.
  - tc is high in the cycle before a wrap edge, so the next cascaded stage steps on that same edge.
- Direction change on consecutive cycles is legal. Each edge uses the up value sampled at that edge.
- q never holds a non-BCD digit after reset, load or count.

Optional Feature:
- Macro: BCD_COUNTER_SATURATE_EN.
- Defined:
  - The counter saturates instead of wrapping: all 9s + up stays all 9s; all 0s + down stays all 0s.
  - wrap is set on any enabled count attempt made while at the limit in the current direction. Reset/load clear rules are unchanged.
  - tc is still asserted at the limit.
- Undefined: wrap-around behaviour exactly as in Behaviour.

Test Plan (DIGITS=2 unless noted):
- Assert rs mid-count with q=0x57, between ck edges -> q=0x00 and wrap=0 before the next edge. Hold en=1 with rs=1 for 3 edges -> q stays 0x00.
- ld=1, ld_val=0x98, en=1, up=1; then ld=0 for 2 edges:
  - q: 0x98 -> 0x99 -> 0x00.
  - tc=1 during the 0x99 cycle.
  - wrap=1 after the 0x00 edge.
- ld_val=0x10, up=0, en=1 for 3 edges:
  - q: 0x10 -> 0x09 -> 0x08 -> 0x07.
  - Then load 0x00 and one down edge -> q=0x99, wrap=1.
- ld=1 and en=1 on the same edge with ld_val=0xA3 -> q=0x03 (invalid digit zeroed), no count step, wrap cleared.
- DIGITS=3, load 0x999, one up edge -> q=0x000, wrap=1. Then a free run of 1000 up edges returns q=0x000 with every intermediate value valid BCD.
- With BCD_COUNTER_SATURATE_EN defined:
  - Load 0x99, 2 up edges -> q stays 0x99, wrap=1.
  - Load 0x00, 1 down edge -> q=0x00, wrap=1.

Source files
------------

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - N-digit BCD up/down counter with load, tc and sticky wrap (option: BCD_COUNTER_SATURATE_EN)
module bcd_counter_n #(
    parameter int DIGITS = 2
) (
    input  logic                  ck,
    input  logic                  rs,
    input  logic                  en,
    input  logic                  up,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   ld_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap
);

    logic [4*DIGITS-1:0] q_cnt;
    logic [4*DIGITS-1:0] q_ld;
    logic                at_max;
    logic                at_min;
    logic                at_lim;
    logic                carry;
    logic [3:0]          dig;
    logic [3:0]          ldig;

    // Ripple the step condition from digit 0 upward: a digit moves only
    // when every lower digit sits at its rollover value for this direction.
    always_comb begin
        q_cnt  = q;
        q_ld   = '0;
        at_max = 1'b1;
        at_min = 1'b1;
        carry  = 1'b1;
        dig    = '0;
        ldig   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dig  = q[4*d +: 4];
            ldig = ld_val[4*d +: 4];
            q_ld[4*d +: 4] = (ldig > 4'd9) ? 4'd0 : ldig;
            at_max = at_max & (dig == 4'd9);
            at_min = at_min & (dig == 4'd0);
            if (carry) begin
                if (up)
                    q_cnt[4*d +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                else
                    q_cnt[4*d +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            carry = carry & (up ? (dig == 4'd9) : (dig == 4'd0));
        end
    end

    assign at_lim = up ? at_max : at_min;
    assign tc     = en & ~ld & at_lim;

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (ld) begin
            q    <= q_ld;
            wrap <= 1'b0;
        end else if (en) begin
            wrap <= wrap | at_lim;
`ifdef BCD_COUNTER_SATURATE_EN
            if (!at_lim)
                q <= q_cnt;
`else
            q <= q_cnt;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - scoreboard bench for bcd_counter_n (2- and 3-digit instances)
module tb_bcd_counter_n;

`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int          id;
        bit          sel;
        logic [11:0] q;
        logic        tc;
        logic        wrap;
    } exp_t;

    logic        ck = 1'b0;
    logic        rs = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        ld = 1'b0;
    logic [11:0] lv = '0;
    logic [7:0]  q2;
    logic [11:0] q3;
    logic        tc2, tc3, wrap2, wrap3;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_id = 0;

    bcd_counter_n #(.DIGITS(2)) dut2 (
        .ck(ck), .rs(rs), .en(en), .up(up), .ld(ld), .ld_val(lv[7:0]),
        .q(q2), .tc(tc2), .wrap(wrap2)
    );

    bcd_counter_n #(.DIGITS(3)) dut3 (
        .ck(ck), .rs(rs), .en(en), .up(up), .ld(ld), .ld_val(lv),
        .q(q3), .tc(tc3), .wrap(wrap3)
    );

    always #5 ck = ~ck;

    // Drive one cycle of inputs just after the edge and queue the values
    // the DUT must show at the following falling edge.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [11:0] v, input bit sel,
                        input logic [11:0] eq, input logic etc, input logic ew);
        exp_t x;
        @(posedge ck);
        #2;
        rs = r; en = e; up = u; ld = l; lv = v;
        x.id = step_id; x.sel = sel; x.q = eq; x.tc = etc; x.wrap = ew;
        exp_q.push_back(x);
        step_id++;
    endtask

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    initial begin : monitor
        exp_t x;
        logic [11:0] aq;
        logic        atc, aw;
        forever begin
            @(negedge ck);
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                aq  = x.sel ? q3 : {4'h0, q2};
                atc = x.sel ? tc3 : tc2;
                aw  = x.sel ? wrap3 : wrap2;
                n_cmp += 3;
                if (aq !== x.q) begin
                    n_bad++;
                    $display("FAIL step%0d q got %h want %h", x.id, aq, x.q);
                end
                if (atc !== x.tc) begin
                    n_bad++;
                    $display("FAIL step%0d tc got %b want %b", x.id, atc, x.tc);
                end
                if (aw !== x.wrap) begin
                    n_bad++;
                    $display("FAIL step%0d wrap got %b want %b", x.id, aw, x.wrap);
                end
            end
        end
    end

    initial begin : stim
        logic [11:0] exp3;
        repeat (2) @(posedge ck);
        // reset state
        step(0, 0, 0, 0, 12'h000, 0, 12'h00, 0, 0);
        // count to 0x57 then assert rs between edges
        step(0, 0, 0, 1, 12'h055, 0, 12'h00, 0, 0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h55, 0, 0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h56, 0, 0);
        step(0, 0, 1, 0, 12'h000, 0, 12'h57, 0, 0);
        step(1, 1, 1, 0, 12'h000, 0, 12'h00, 0, 0);
        step(1, 1, 1, 0, 12'h000, 0, 12'h00, 0, 0);
        step(1, 1, 1, 0, 12'h000, 0, 12'h00, 0, 0);
        step(0, 0, 1, 0, 12'h000, 0, 12'h00, 0, 0);
        // up wrap 98 -> 99 -> 00
        step(0, 1, 1, 1, 12'h098, 0, 12'h00, 0, 0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h98, 0, 0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h99, 1, 0);
        step(0, 0, 1, 0, 12'h000, 0, SAT ? 12'h99 : 12'h00, 0, 1);
        // down across the tens digit, then down wrap 00 -> 99
        step(0, 1, 0, 1, 12'h010, 0, SAT ? 12'h99 : 12'h00, 0, 1);
        step(0, 1, 0, 0, 12'h000, 0, 12'h10, 0, 0);
        step(0, 1, 0, 0, 12'h000, 0, 12'h09, 0, 0);
        step(0, 1, 0, 0, 12'h000, 0, 12'h08, 0, 0);
        step(0, 0, 0, 1, 12'h000, 0, 12'h07, 0, 0);
        step(0, 1, 0, 0, 12'h000, 0, 12'h00, 1, 0);
        step(0, 0, 0, 0, 12'h000, 0, SAT ? 12'h00 : 12'h99, 0, 1);
        // load beats enable; invalid digit loads as 0; wrap cleared
        step(0, 1, 1, 1, 12'h0A3, 0, SAT ? 12'h00 : 12'h99, 0, 1);
        step(0, 1, 1, 0, 12'h000, 0, 12'h03, 0, 0);
        step(0, 1, 0, 0, 12'h000, 0, 12'h04, 0, 0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h03, 0, 0);
        step(0, 1, 0, 0, 12'h000, 0, 12'h04, 0, 0);
        step(0, 0, 0, 0, 12'h000, 0, 12'h03, 0, 0);
        // three-digit instance: 999 wrap then a full 1000-edge lap
        step(1, 0, 0, 0, 12'h000, 1, 12'h000, 0, 0);
        step(0, 0, 0, 1, 12'h999, 1, 12'h000, 0, 0);
        step(0, 1, 1, 0, 12'h000, 1, 12'h999, 1, 0);
        for (int i = 0; i < 1000; i++) begin
            exp3 = SAT ? 12'h999 : to_bcd(i);
            step(0, 1, 1, 0, 12'h000, 1, exp3, SAT ? 1'b1 : (i == 999), 1);
        end
        step(0, 0, 1, 0, 12'h000, 1, SAT ? 12'h999 : 12'h000, 0, 1);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            @(posedge ck);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain queue left %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
